// File: rtl/ex_mdu_iter_if.sv
// EX-stage multiply/divide unit bus: pipeline controls and operands in,
// stall/status and the architectural HI/LO registers out.
interface ex_mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             hold;
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stallreq;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, hold, op_valid, op, src_a, src_b,
    input  stallreq, busy, done, hi, lo
  );

  modport slave (
    input  flush, hold, op_valid, op, src_a, src_b,
    output stallreq, busy, done, hi, lo
  );
endinterface

// File: rtl/ex_mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: magnitude shift-add / restoring
// divide, BITS_PER_CYCLE radix-2 steps per cycle, sign fix-up on the HI/LO write.
module ex_mdu_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  ex_mdu_iter_if.slave bus
);
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Instruction decode
  logic is_mul_op, is_div_op, is_signed_op, is_arith_op, is_mt_op;
  logic start, mt_wr, res_we;

  assign is_mul_op    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_arith_op  = is_mul_op || is_div_op;
  assign is_mt_op     = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);

  assign start = (state_q == S_IDLE) && bus.op_valid && is_arith_op && !bus.flush;
  assign mt_wr = (state_q == S_IDLE) && bus.op_valid && is_mt_op && !bus.flush && !bus.hold;
  assign res_we = (state_q == S_DONE) && !bus.hold && !bus.flush;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as an unsigned magnitude
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed_op && bus.src_a[WIDTH-1];
  assign b_neg = is_signed_op && bus.src_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

  // acc_lo holds the multiplier (mul) or the dividend being shifted out (div);
  // acc_hi holds the running upper product (mul) or the partial remainder (div).
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   step_tmp;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step_hi  = acc_hi_q;
    step_lo  = acc_lo_q;
    step_tmp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        step_tmp = {step_hi, step_lo[WIDTH-1]} - {1'b0, mag_b_q};
        if (step_tmp[WIDTH]) begin
          step_hi = {step_hi[WIDTH-2:0], step_lo[WIDTH-1]};
        end else begin
          step_hi = step_tmp[WIDTH-1:0];
        end
        step_lo = {step_lo[WIDTH-2:0], ~step_tmp[WIDTH]};
      end else begin
        step_tmp = {1'b0, step_hi} + (step_lo[0] ? {1'b0, mag_b_q} : '0);
        step_lo  = {step_tmp[0], step_lo[WIDTH-1:1]};
        step_hi  = step_tmp[WIDTH:1];
      end
    end
  end

  // Sign fix-up applied only on the way into HI/LO
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    if (is_div_q) begin
      res_lo = neg_res_q ? -acc_lo_q : acc_lo_q;
      res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Next state and status outputs
  logic stallreq, busy, done;

  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        stallreq = start;
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        stallreq = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag_b_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
    end else if (start) begin
      cnt_q     <= '0;
      is_div_q  <= is_div_op;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      mag_b_q   <= b_mag;
      acc_hi_q  <= '0;
      acc_lo_q  <= a_mag;
    end else if ((state_q == S_CALC) && !bus.flush) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  // HI/LO change only on a completed operation or an MTHI/MTLO in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (res_we) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (mt_wr) begin
      if (bus.op == OP_MTHI) hi_q <= bus.src_a;
      else                   lo_q <= bus.src_a;
    end
  end

  assign bus.stallreq = stallreq;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_ex_mdu_iter.sv
// Scoreboard bench for ex_mdu_iter: directed vectors on W=32/BPC=1, 2, 4 and W=16/BPC=4;
// a negedge monitor pops expected HI/LO whenever a DONE->IDLE write happens.
`timescale 1ns/1ps
module tb_ex_mdu_iter;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mdu_iter_if #(.WIDTH(32)) b0 ();
  ex_mdu_iter_if #(.WIDTH(32)) b1 ();
  ex_mdu_iter_if #(.WIDTH(32)) b2 ();
  ex_mdu_iter_if #(.WIDTH(16)) b3 ();

  ex_mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  ex_mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ex_mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  ex_mdu_iter #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  vec_t v32[$];
  vec_t v16[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic sb_push(input int k, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic sb_compare(input int k, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    int   sz;
    case (k)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = q3.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL sb%0d_unexpected: got hi=%h lo=%h, required no write", k, hi, lo);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      check($sformatf("sb%0d_hi", k), {32'h0, hi}, {32'h0, e.hi});
      check($sformatf("sb%0d_lo", k), {32'h0, lo}, {32'h0, e.lo});
    end
  endtask

  // Monitor: a DONE cycle with hold=0 writes HI/LO on the next edge; compare one half-cycle later
  logic [3:0] pend = '0;
  always @(negedge clk) begin
    if (pend[0]) sb_compare(0, b0.hi, b0.lo);
    if (pend[1]) sb_compare(1, b1.hi, b1.lo);
    if (pend[2]) sb_compare(2, b2.hi, b2.lo);
    if (pend[3]) sb_compare(3, {16'h0, b3.hi}, {16'h0, b3.lo});
    pend <= {b3.done & ~b3.hold & ~b3.flush & ~rst,
             b2.done & ~b2.hold & ~b2.flush & ~rst,
             b1.done & ~b1.hold & ~b1.flush & ~rst,
             b0.done & ~b0.hold & ~b0.flush & ~rst};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arithmetic op on the W=32/BPC=1 unit; the instruction stays in EX until DONE
  task automatic run_op(input vec_t v, input int hold_cycles);
    int          stall;
    bit          seen_done;
    logic [31:0] hi0, lo0;
    sb_push(0, v.hi, v.lo);
    hi0 = b0.hi;
    lo0 = b0.lo;
    b0.op_valid = 1'b1;
    b0.op       = v.op;
    b0.src_a    = v.a;
    b0.src_b    = v.b;
    b0.hold     = (hold_cycles > 0);
    stall       = 0;
    seen_done   = 1'b0;
    @(negedge clk);
    if (b0.stallreq) stall++;
    tick();
    b0.src_a = ~v.a;
    b0.src_b = ~v.b;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge clk);
      if (b0.stallreq) stall++;
      else seen_done = 1'b1;
    end
    check("stall_cycles", 64'(stall), 64'd33);
    check("done_state", {63'h0, b0.done}, 64'd1);
    b0.op_valid = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      check("hold_done", {63'h0, b0.done}, 64'd1);
      check("hold_hi_kept", {32'h0, b0.hi}, {32'h0, hi0});
      check("hold_lo_kept", {32'h0, b0.lo}, {32'h0, lo0});
      tick();
      if (i == hold_cycles - 1) b0.hold = 1'b0;
      @(negedge clk);
    end
    tick();
    check("idle_after_done", {63'h0, b0.busy}, 64'd0);
  endtask

  task automatic run_sweep32(input vec_t v);
    sb_push(1, v.hi, v.lo);
    sb_push(2, v.hi, v.lo);
    b1.op_valid = 1'b1; b1.op = v.op; b1.src_a = v.a; b1.src_b = v.b;
    b2.op_valid = 1'b1; b2.op = v.op; b2.src_a = v.a; b2.src_b = v.b;
    tick();
    b1.op_valid = 1'b0;
    b2.op_valid = 1'b0;
    for (int i = 0; i < 100 && (b1.busy || b2.busy); i++) tick();
    check("sweep32_idle", {62'h0, b1.busy, b2.busy}, 64'd0);
    tick();
  endtask

  task automatic run_sweep16(input vec_t v);
    sb_push(3, v.hi, v.lo);
    b3.op_valid = 1'b1; b3.op = v.op; b3.src_a = v.a[15:0]; b3.src_b = v.b[15:0];
    tick();
    b3.op_valid = 1'b0;
    for (int i = 0; i < 100 && b3.busy; i++) tick();
    check("sweep16_idle", {63'h0, b3.busy}, 64'd0);
    tick();
  endtask

  initial begin
    // W=32 vectors with hand-computed {hi, lo}
    v32.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1));
    v32.push_back(mk(OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E));
    v32.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD));
    v32.push_back(mk(OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF));
    v32.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000));
    v32.push_back(mk(OP_MULT,  32'h12345678, 32'h00000002, 32'h00000000, 32'h2468ACF0));
    v32.push_back(mk(OP_MULT,  32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018));
    v32.push_back(mk(OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2));
    v32.push_back(mk(OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E));
    v32.push_back(mk(OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000));
    v32.push_back(mk(OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000));
    v32.push_back(mk(OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001));
    v32.push_back(mk(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000));
    v32.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001));
    // W=16 vectors
    v16.push_back(mk(OP_MULT,  32'hFFFD, 32'h0005, 32'hFFFF, 32'hFFF1));
    v16.push_back(mk(OP_MULTU, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001));
    v16.push_back(mk(OP_DIVU,  32'h0064, 32'h0007, 32'h0002, 32'h000E));
    v16.push_back(mk(OP_DIV,   32'hFFF9, 32'h0002, 32'hFFFF, 32'hFFFD));
    v16.push_back(mk(OP_DIV,   32'h8000, 32'hFFFF, 32'h0000, 32'h8000));
    v16.push_back(mk(OP_DIVU,  32'h0005, 32'h0000, 32'h0005, 32'hFFFF));
    v16.push_back(mk(OP_DIV,   32'h03E8, 32'hFFFD, 32'h0001, 32'hFEB3));

    rst = 1'b1;
    b0.flush = 1'b0; b0.hold = 1'b0; b0.op_valid = 1'b0; b0.op = OP_NONE; b0.src_a = '0; b0.src_b = '0;
    b1.flush = 1'b0; b1.hold = 1'b0; b1.op_valid = 1'b0; b1.op = OP_NONE; b1.src_a = '0; b1.src_b = '0;
    b2.flush = 1'b0; b2.hold = 1'b0; b2.op_valid = 1'b0; b2.op = OP_NONE; b2.src_a = '0; b2.src_b = '0;
    b3.flush = 1'b0; b3.hold = 1'b0; b3.op_valid = 1'b0; b3.op = OP_NONE; b3.src_a = '0; b3.src_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi", {32'h0, b0.hi}, 64'h0);
    check("rst_lo", {32'h0, b0.lo}, 64'h0);
    check("rst_status", {61'h0, b0.stallreq, b0.busy, b0.done}, 64'h0);
    tick();

    // Directed arithmetic vectors, last one with hold=1 for three DONE cycles
    for (int i = 0; i < v32.size() - 1; i++) run_op(v32[i], 0);
    run_op(v32[v32.size() - 1], 3);
    tick();
    @(negedge clk);
    check("multu_single_write_hi", {32'h0, b0.hi}, 64'hFFFFFFFE);
    check("multu_single_write_lo", {32'h0, b0.lo}, 64'h00000001);
    tick();

    // Flush a DIV in its 5th CALC cycle
    b0.op_valid = 1'b1; b0.op = OP_DIV; b0.src_a = 32'hFFFFFFF9; b0.src_b = 32'h2;
    tick();
    b0.op_valid = 1'b0;
    repeat (3) tick();
    tick();
    b0.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {63'h0, b0.busy}, 64'd1);
    tick();
    b0.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'h0, b0.busy}, 64'd0);
    check("flush_stallreq", {63'h0, b0.stallreq}, 64'd0);
    check("flush_hi", {32'h0, b0.hi}, 64'hFFFFFFFE);
    check("flush_lo", {32'h0, b0.lo}, 64'h00000001);
    tick();

    // Reset in the middle of CALC
    b0.op_valid = 1'b1; b0.op = OP_MULT; b0.src_a = 32'h7; b0.src_b = 32'h9;
    tick();
    b0.op_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstcalc_hi", {32'h0, b0.hi}, 64'h0);
    check("rstcalc_lo", {32'h0, b0.lo}, 64'h0);
    check("rstcalc_status", {61'h0, b0.stallreq, b0.busy, b0.done}, 64'h0);
    tick();

    // MTHI then MTLO back to back
    b0.op_valid = 1'b1; b0.op = OP_MTHI; b0.src_a = 32'h1234;
    @(negedge clk);
    check("mthi_stallreq", {63'h0, b0.stallreq}, 64'd0);
    tick();
    b0.op = OP_MTLO; b0.src_a = 32'h5678;
    @(negedge clk);
    check("mtlo_stallreq", {63'h0, b0.stallreq}, 64'd0);
    check("mthi_hi", {32'h0, b0.hi}, 64'h1234);
    tick();
    b0.op_valid = 1'b0;
    @(negedge clk);
    check("mt_hi", {32'h0, b0.hi}, 64'h1234);
    check("mt_lo", {32'h0, b0.lo}, 64'h5678);
    check("mt_busy", {63'h0, b0.busy}, 64'd0);

    // MTLO held off by hold
    tick();
    b0.hold = 1'b1; b0.op_valid = 1'b1; b0.op = OP_MTLO; b0.src_a = 32'hABCD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mtlo_hold_lo", {32'h0, b0.lo}, 64'h5678);
      tick();
    end
    b0.hold = 1'b0;
    @(negedge clk);
    check("mtlo_prewrite_lo", {32'h0, b0.lo}, 64'h5678);
    tick();
    b0.op_valid = 1'b0;
    @(negedge clk);
    check("mtlo_released_lo", {32'h0, b0.lo}, 64'hABCD);
    check("mtlo_released_hi", {32'h0, b0.hi}, 64'h1234);

    // Reserved and NONE ops have no effect
    tick();
    b0.op_valid = 1'b1; b0.op = OP_RSVD; b0.src_a = 32'hDEAD; b0.src_b = 32'h1;
    @(negedge clk);
    check("rsvd_stallreq", {63'h0, b0.stallreq}, 64'd0);
    tick();
    b0.op = OP_NONE;
    tick();
    b0.op_valid = 1'b0;
    @(negedge clk);
    check("rsvd_busy", {63'h0, b0.busy}, 64'd0);
    check("rsvd_hi", {32'h0, b0.hi}, 64'h1234);
    check("rsvd_lo", {32'h0, b0.lo}, 64'hABCD);
    tick();

    // Other widths / step counts
    for (int i = 0; i < v32.size(); i++) run_sweep32(v32[i]);
    for (int i = 0; i < v16.size(); i++) run_sweep16(v16[i]);

    repeat (3) tick();
    check("sb0_drained", 64'(q0.size()), 64'd0);
    check("sb1_drained", 64'(q1.size()), 64'd0);
    check("sb2_drained", 64'(q2.size()), 64'd0);
    check("sb3_drained", 64'(q3.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
